// File: rtl/cfg_iosf_req_initiator_pkg.sv
// Shared types for the IOSF-to-config-bus request initiator: command, request,
// ack and completion formats plus the opcode translation helpers.
package cfg_iosf_req_initiator_pkg;

    localparam logic [7:0] IOSF_MRD32  = 8'h00;
    localparam logic [7:0] IOSF_MRD64  = 8'h20;
    localparam logic [7:0] IOSF_MWR32  = 8'h40;
    localparam logic [7:0] IOSF_MWR64  = 8'h60;
    localparam logic [7:0] IOSF_IORD   = 8'h02;
    localparam logic [7:0] IOSF_IOWR   = 8'h42;
    localparam logic [7:0] IOSF_CFGRD0 = 8'h04;
    localparam logic [7:0] IOSF_CFGWR0 = 8'h44;
    localparam logic [7:0] IOSF_SWAP64 = 8'h6D;

    typedef enum logic [3:0] {
        CFGRD = 4'h0,
        CFGWR = 4'h1,
        MRD   = 4'h2,
        MWR   = 4'h3,
        IORD  = 4'h4,
        IOWR  = 4'h5
    } cfg_opcode_t;

    typedef enum logic [1:0] {
        CPL_SC = 2'd0,
        CPL_UR = 2'd1,
        CPL_CA = 2'd2
    } cfg_cpl_status_t;

    typedef struct packed {
        logic [13:0] rsvd;
        logic [7:0]  opcode;
        logic [7:0]  tag;
        logic [15:0] rqid;
        logic [9:0]  length;
        logic [3:0]  lbe;
        logic [3:0]  fbe;
        logic [63:0] address;
    } cfg_iosf_cmd_t;

    typedef struct packed {
        logic        valid;
        cfg_opcode_t opcode;
        logic [47:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
        logic [23:0] sai;
        logic [7:0]  fid;
    } cfg_req_64bit_t;

    typedef struct packed {
        logic        read_valid;
        logic        read_miss;
        logic        write_valid;
        logic        write_miss;
        logic [63:0] data;
    } cfg_ack_64bit_t;

    typedef struct packed {
        logic        supported;
        cfg_opcode_t opcode;
    } cfg_op_map_t;

    function automatic cfg_op_map_t IosfToCfgOpcode(input logic [7:0] op);
        cfg_op_map_t m;
        m.supported = 1'b1;
        m.opcode    = CFGRD;
        case (op)
            IOSF_MRD32, IOSF_MRD64: m.opcode = MRD;
            IOSF_MWR32, IOSF_MWR64: m.opcode = MWR;
            IOSF_IORD:              m.opcode = IORD;
            IOSF_IOWR:              m.opcode = IOWR;
            IOSF_CFGRD0:            m.opcode = CFGRD;
            IOSF_CFGWR0:            m.opcode = CFGWR;
            default:                m.supported = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic CmdParity(input cfg_iosf_cmd_t c);
        return ^c;
    endfunction

    function automatic logic IsReadOp(input cfg_opcode_t op);
        return (op == CFGRD) || (op == MRD) || (op == IORD);
    endfunction

endpackage

// File: rtl/cfg_iosf_req_initiator_if.sv
// Command, config-bus and completion signals of the request initiator.
interface cfg_iosf_req_initiator_if;
    import cfg_iosf_req_initiator_pkg::*;

    logic            cmd_valid;
    logic            cmd_ready;
    cfg_iosf_cmd_t   cmd;
    logic            cmd_par;
    logic [63:0]     cmd_wdata;
    logic [23:0]     cmd_sai;
    logic [7:0]      cmd_fid;
    cfg_req_64bit_t  cfg_req;
    cfg_ack_64bit_t  cfg_ack;
    logic            cpl_valid;
    logic            cpl_ready;
    cfg_cpl_status_t cpl_status;
    logic [63:0]     cpl_data;
    logic [7:0]      cpl_tag;
    logic [15:0]     cpl_rqid;
    logic            par_err;
    logic            posted_err;
    logic            stray_ack;

    modport master (
        input  cmd_valid, cmd, cmd_par, cmd_wdata, cmd_sai, cmd_fid, cfg_ack, cpl_ready,
        output cmd_ready, cfg_req, cpl_valid, cpl_status, cpl_data, cpl_tag, cpl_rqid,
               par_err, posted_err, stray_ack
    );

    modport slave (
        output cmd_valid, cmd, cmd_par, cmd_wdata, cmd_sai, cmd_fid, cfg_ack, cpl_ready,
        input  cmd_ready, cfg_req, cpl_valid, cpl_status, cpl_data, cpl_tag, cpl_rqid,
               par_err, posted_err, stray_ack
    );

endinterface

// File: rtl/cfg_iosf_req_initiator_decode.sv
// Combinational command check and translation: parity, opcode map, legality
// checks and offset/byte-enable formation for one config-bus request.
module cfg_iosf_req_initiator_decode
    import cfg_iosf_req_initiator_pkg::*;
(
    input  cfg_iosf_cmd_t   cmd,
    input  logic            cmd_par,
    input  logic [63:0]     cmd_wdata,
    input  logic [23:0]     cmd_sai,
    input  logic [7:0]      cmd_fid,
    output cfg_req_64bit_t  req,
    output cfg_cpl_status_t status,
    output logic            par_ok
);

    cfg_op_map_t map;
    logic        len_ok;
    logic        addr_ok;
    logic        align_ok;

    always_comb begin
        map      = IosfToCfgOpcode(cmd.opcode);
        par_ok   = (cmd_par == CmdParity(cmd));
        len_ok   = (cmd.length == 10'd1) || (cmd.length == 10'd2);
        addr_ok  = (cmd.address[63:48] == 16'h0);
        align_ok = !((cmd.length == 10'd2) && cmd.address[2]);

        req        = '0;
        req.valid  = 1'b1;
        req.opcode = map.opcode;
        req.sai    = cmd_sai;
        req.fid    = cmd_fid;

        case (map.opcode)
            MRD, MWR:   req.addr = {cmd.address[47:3], 3'b000};
            IORD, IOWR: req.addr = {32'h0, cmd.address[15:3], 3'b000};
            default:    req.addr = {36'h0, cmd.address[11:3], 3'b000};
        endcase

        // A single DWORD lands in the upper or lower half of the qword lane.
        if (cmd.length == 10'd2) begin
            req.be = {cmd.lbe, cmd.fbe};
        end else if (cmd.address[2]) begin
            req.be = {cmd.fbe, 4'h0};
        end else begin
            req.be = {4'h0, cmd.fbe};
        end

        req.data = IsReadOp(map.opcode) ? 64'h0 : cmd_wdata;

        if (!par_ok) begin
            status = CPL_CA;
        end else if (!(map.supported && len_ok && addr_ok && align_ok)) begin
            status = CPL_UR;
        end else begin
            status = CPL_SC;
        end
    end

endmodule

// File: rtl/cfg_iosf_req_initiator.sv
// Serialized initiator: accepts one IOSF command, issues one config request,
// waits for its ack (or timeout) and returns a completion unless posted.
module cfg_iosf_req_initiator
    import cfg_iosf_req_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMR_W          = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    cfg_iosf_req_initiator_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CPL
    } state_t;

    state_t          state_q, state_d;
    cfg_req_64bit_t  dec_req, req_q;
    cfg_cpl_status_t dec_status, status_q, status_d;
    logic            dec_par_ok;
    logic [TMR_W-1:0] tmr_q;
    logic [63:0]     cpl_data_q, cpl_data_d;
    logic [7:0]      tag_q;
    logic [15:0]     rqid_q;
    logic            par_err_q, posted_err_q, stray_ack_q;
    logic            par_err_d, posted_err_d, stray_ack_d;
    logic            accept, is_read, posted, ack_hit, ack_miss, timeout;

    cfg_iosf_req_initiator_decode u_decode (
        .cmd       (bus.cmd),
        .cmd_par   (bus.cmd_par),
        .cmd_wdata (bus.cmd_wdata),
        .cmd_sai   (bus.cmd_sai),
        .cmd_fid   (bus.cmd_fid),
        .req       (dec_req),
        .status    (dec_status),
        .par_ok    (dec_par_ok)
    );

    assign accept   = (state_q == S_IDLE) && bus.cmd_valid;
    assign is_read  = IsReadOp(req_q.opcode);
    assign posted   = (req_q.opcode == MWR);
    assign ack_hit  = is_read ? bus.cfg_ack.read_valid : bus.cfg_ack.write_valid;
    assign ack_miss = is_read ? bus.cfg_ack.read_miss  : bus.cfg_ack.write_miss;
    assign timeout  = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        cpl_data_d   = cpl_data_q;
        par_err_d    = 1'b0;
        posted_err_d = 1'b0;
        stray_ack_d  = (state_q != S_WAIT) &&
                       (bus.cfg_ack.read_valid  || bus.cfg_ack.read_miss ||
                        bus.cfg_ack.write_valid || bus.cfg_ack.write_miss);
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    status_d   = dec_status;
                    cpl_data_d = '0;
                    par_err_d  = !dec_par_ok;
                    state_d    = (dec_status == CPL_SC) ? S_ISSUE : S_CPL;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // An ack arriving in the final timer cycle still wins.
                if (ack_hit || timeout) begin
                    if (posted) begin
                        state_d      = S_IDLE;
                        posted_err_d = ack_hit ? ack_miss : 1'b1;
                    end else begin
                        state_d = S_CPL;
                        if (!ack_hit) begin
                            status_d = CPL_CA;
                        end else if (ack_miss) begin
                            status_d = CPL_UR;
                        end else begin
                            status_d = CPL_SC;
                        end
                        cpl_data_d = (ack_hit && is_read && !ack_miss) ? bus.cfg_ack.data : 64'h0;
                    end
                end
            end
            S_CPL: begin
                if (bus.cpl_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            par_err_q    <= 1'b0;
            posted_err_q <= 1'b0;
            stray_ack_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= (state_q == S_WAIT) ? tmr_q + TMR_W'(1) : '0;
            par_err_q    <= par_err_d;
            posted_err_q <= posted_err_d;
            stray_ack_q  <= stray_ack_d;
        end
    end

    // Transaction payload is qualified by state, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_q  <= dec_req;
            tag_q  <= bus.cmd.tag;
            rqid_q <= bus.cmd.rqid;
        end
        status_q   <= status_d;
        cpl_data_q <= cpl_data_d;
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.cfg_req    = (state_q == S_ISSUE) ? req_q : '0;
    assign bus.cpl_valid  = (state_q == S_CPL);
    assign bus.cpl_status = bus.cpl_valid ? status_q : CPL_SC;
    assign bus.cpl_data   = bus.cpl_valid ? cpl_data_q : 64'h0;
    assign bus.cpl_tag    = bus.cpl_valid ? tag_q : 8'h0;
    assign bus.cpl_rqid   = bus.cpl_valid ? rqid_q : 16'h0;
    assign bus.par_err    = par_err_q;
    assign bus.posted_err = posted_err_q;
    assign bus.stray_ack  = stray_ack_q;

endmodule

// File: tb/tb_cfg_iosf_req_initiator.sv
// Scoreboard bench for cfg_iosf_req_initiator with a short timeout.
module tb_cfg_iosf_req_initiator;
    import cfg_iosf_req_initiator_pkg::*;

    localparam int TO = 16;

    typedef struct packed {
        cfg_opcode_t op;
        logic [47:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
        logic [23:0] sai;
        logic [7:0]  fid;
    } exp_req_t;

    typedef struct packed {
        cfg_cpl_status_t st;
        logic [63:0]     data;
        logic [7:0]      tag;
        logic [15:0]     rqid;
    } exp_cpl_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_par = 0;
    int   n_posted = 0;
    int   n_stray = 0;
    exp_req_t exp_req_q[$];
    exp_cpl_t exp_cpl_q[$];
    exp_req_t er;
    exp_cpl_t ec;

    cfg_iosf_req_initiator_if bus ();

    cfg_iosf_req_initiator #(.TIMEOUT_CYCLES(TO), .TMR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, required end within time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic cfg_iosf_cmd_t mk(input logic [7:0] op, input logic [7:0] tag,
                                         input logic [15:0] rqid, input logic [9:0] len,
                                         input logic [3:0] fbe, input logic [3:0] lbe,
                                         input logic [63:0] addr);
        cfg_iosf_cmd_t c;
        c         = '0;
        c.opcode  = op;
        c.tag     = tag;
        c.rqid    = rqid;
        c.length  = len;
        c.fbe     = fbe;
        c.lbe     = lbe;
        c.address = addr;
        return c;
    endfunction

    // Returns one cycle after the accept edge, i.e. in the request cycle.
    task automatic send_cmd(input cfg_iosf_cmd_t c, input logic flip, input logic [63:0] wd,
                            input logic [23:0] sai, input logic [7:0] fid);
        int n = 0;
        while (!bus.cmd_ready && n < 50) begin
            tick(1);
            n++;
        end
        chk("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
        bus.cmd       = c;
        bus.cmd_par   = (^c) ^ flip;
        bus.cmd_wdata = wd;
        bus.cmd_sai   = sai;
        bus.cmd_fid   = fid;
        bus.cmd_valid = 1'b1;
        tick(1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic ack_pulse(input logic rv, input logic rm, input logic wv, input logic wm,
                             input logic [63:0] d);
        bus.cfg_ack = cfg_ack_64bit_t'({rv, rm, wv, wm, d});
        tick(1);
        bus.cfg_ack = '0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.par_err)    n_par++;
            if (bus.posted_err) n_posted++;
            if (bus.stray_ack)  n_stray++;
            if (bus.cfg_req.valid) begin
                chk("req_expected", 64'(exp_req_q.size() != 0), 64'd1);
                if (exp_req_q.size() != 0) begin
                    er = exp_req_q.pop_front();
                    chk("req_opcode", 64'(bus.cfg_req.opcode), 64'(er.op));
                    chk("req_addr", 64'(bus.cfg_req.addr), 64'(er.addr));
                    chk("req_be", 64'(bus.cfg_req.be), 64'(er.be));
                    chk("req_data", bus.cfg_req.data, er.data);
                    chk("req_sai", 64'(bus.cfg_req.sai), 64'(er.sai));
                    chk("req_fid", 64'(bus.cfg_req.fid), 64'(er.fid));
                end
            end else begin
                chk("req_zero_idle", 64'(bus.cfg_req != '0), 64'd0);
            end
            if (bus.cpl_valid && bus.cpl_ready) begin
                chk("cpl_expected", 64'(exp_cpl_q.size() != 0), 64'd1);
                if (exp_cpl_q.size() != 0) begin
                    ec = exp_cpl_q.pop_front();
                    chk("cpl_status", 64'(bus.cpl_status), 64'(ec.st));
                    chk("cpl_data", bus.cpl_data, ec.data);
                    chk("cpl_tag", 64'(bus.cpl_tag), 64'(ec.tag));
                    chk("cpl_rqid", 64'(bus.cpl_rqid), 64'(ec.rqid));
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = '0;
        bus.cmd_par   = 1'b0;
        bus.cmd_wdata = '0;
        bus.cmd_sai   = '0;
        bus.cmd_fid   = '0;
        bus.cfg_ack   = '0;
        bus.cpl_ready = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_cpl_valid", 64'(bus.cpl_valid), 64'd0);
        chk("rst_cfg_req", 64'(bus.cfg_req != '0), 64'd0);
        chk("rst_cpl_data", bus.cpl_data, 64'd0);
        chk("rst_pulses", 64'({bus.par_err, bus.posted_err, bus.stray_ack}), 64'd0);

        // MRD64 length 2, ignored write ack at k=1, read ack at k=3
        exp_req_q.push_back('{MRD, 48'h1000, 8'hFF, 64'h0, 24'h000111, 8'h01});
        exp_cpl_q.push_back('{CPL_SC, 64'hDEADBEEF_01234567, 8'h11, 16'h0100});
        send_cmd(mk(IOSF_MRD64, 8'h11, 16'h0100, 10'd2, 4'hF, 4'hF, 64'h1000), 1'b0,
                 64'hFFFF0000_FFFF0000, 24'h000111, 8'h01);
        chk("mrd_req_cycle", 64'(bus.cfg_req.valid), 64'd1);
        tick(1);
        ack_pulse(1'b0, 1'b0, 1'b1, 1'b0, 64'h5555);
        chk("mrd_opposite_ack_ignored", 64'(bus.cpl_valid), 64'd0);
        tick(1);
        chk("mrd_no_early_cpl", 64'(bus.cpl_valid), 64'd0);
        ack_pulse(1'b1, 1'b0, 1'b0, 1'b0, 64'hDEADBEEF_01234567);
        chk("mrd_cpl_latency", 64'(bus.cpl_valid), 64'd1);
        chk("mrd_cpl_data", bus.cpl_data, 64'hDEADBEEF_01234567);
        tick(1);

        // CFGWR0 single DWORD in upper half, write miss -> UR
        exp_req_q.push_back('{CFGWR, 48'h40, 8'hF0, 64'h00000000_CAFEF00D, 24'h000222, 8'h02});
        exp_cpl_q.push_back('{CPL_UR, 64'h0, 8'h22, 16'h0200});
        send_cmd(mk(IOSF_CFGWR0, 8'h22, 16'h0200, 10'd1, 4'hF, 4'h0, 64'h44), 1'b0,
                 64'h00000000_CAFEF00D, 24'h000222, 8'h02);
        tick(1);
        ack_pulse(1'b0, 1'b0, 1'b1, 1'b1, 64'h0);
        chk("cfgwr_cpl_valid", 64'(bus.cpl_valid), 64'd1);
        chk("cfgwr_cpl_status", 64'(bus.cpl_status), 64'(CPL_UR));
        tick(1);

        // posted MWR32 with no ack -> posted_err, no completion
        exp_req_q.push_back('{MWR, 48'h2000, 8'h0F, 64'h1234, 24'h000333, 8'h03});
        send_cmd(mk(IOSF_MWR32, 8'h33, 16'h0300, 10'd1, 4'hF, 4'h0, 64'h2000), 1'b0,
                 64'h1234, 24'h000333, 8'h03);
        tick(TO);
        chk("mwr_busy_last_wait", 64'(bus.cmd_ready), 64'd0);
        tick(1);
        chk("mwr_timeout_ready", 64'(bus.cmd_ready), 64'd1);
        chk("mwr_posted_err", 64'(bus.posted_err), 64'd1);
        tick(1);
        chk("mwr_posted_err_pulse", 64'(bus.posted_err), 64'd0);
        chk("mwr_no_cpl", 64'(bus.cpl_valid), 64'd0);

        // IORD with flipped parity -> CA without a request
        exp_cpl_q.push_back('{CPL_CA, 64'h0, 8'h44, 16'h0400});
        send_cmd(mk(IOSF_IORD, 8'h44, 16'h0400, 10'd1, 4'hF, 4'h0, 64'h10), 1'b1,
                 64'h0, 24'h000444, 8'h04);
        chk("par_err_pulse", 64'(bus.par_err), 64'd1);
        chk("par_cpl_status", 64'(bus.cpl_status), 64'(CPL_CA));
        tick(1);

        // decode failures -> UR without a request
        exp_cpl_q.push_back('{CPL_UR, 64'h0, 8'h55, 16'h0500});
        send_cmd(mk(IOSF_SWAP64, 8'h55, 16'h0500, 10'd2, 4'hF, 4'hF, 64'h100), 1'b0,
                 64'h0, 24'h0, 8'h0);
        chk("swap_ur", 64'(bus.cpl_status), 64'(CPL_UR));
        chk("swap_no_par_err", 64'(bus.par_err), 64'd0);
        tick(1);
        exp_cpl_q.push_back('{CPL_UR, 64'h0, 8'h66, 16'h0600});
        send_cmd(mk(IOSF_MRD64, 8'h66, 16'h0600, 10'd2, 4'hF, 4'hF, 64'h0001_0000_0000_1000),
                 1'b0, 64'h0, 24'h0, 8'h0);
        chk("hiaddr_ur", 64'(bus.cpl_status), 64'(CPL_UR));
        tick(1);
        exp_cpl_q.push_back('{CPL_UR, 64'h0, 8'h67, 16'h0601});
        send_cmd(mk(IOSF_MRD32, 8'h67, 16'h0601, 10'd3, 4'hF, 4'hF, 64'h1000), 1'b0,
                 64'h0, 24'h0, 8'h0);
        tick(1);
        exp_cpl_q.push_back('{CPL_UR, 64'h0, 8'h68, 16'h0602});
        send_cmd(mk(IOSF_MRD32, 8'h68, 16'h0602, 10'd2, 4'hF, 4'hF, 64'h1004), 1'b0,
                 64'h0, 24'h0, 8'h0);
        tick(1);

        // ack during ISSUE is stray; the read then times out
        exp_req_q.push_back('{MRD, 48'h30, 8'h0F, 64'h0, 24'h000777, 8'h07});
        exp_cpl_q.push_back('{CPL_CA, 64'h0, 8'h77, 16'h0700});
        send_cmd(mk(IOSF_MRD32, 8'h77, 16'h0700, 10'd1, 4'hF, 4'h0, 64'h30), 1'b0,
                 64'h0, 24'h000777, 8'h07);
        ack_pulse(1'b1, 1'b0, 1'b0, 1'b0, 64'h99);
        chk("issue_stray_ack", 64'(bus.stray_ack), 64'd1);
        tick(TO - 1);
        chk("stray_still_waiting", 64'(bus.cpl_valid), 64'd0);
        tick(1);
        chk("stray_timeout_ca", 64'(bus.cpl_status), 64'(CPL_CA));
        chk("stray_timeout_valid", 64'(bus.cpl_valid), 64'd1);
        tick(1);

        // ack in the last WAIT cycle beats the timeout
        exp_req_q.push_back('{MRD, 48'h20, 8'hC0, 64'h0, 24'h000888, 8'h08});
        exp_cpl_q.push_back('{CPL_SC, 64'h11223344_55667788, 8'h88, 16'h0800});
        send_cmd(mk(IOSF_MRD32, 8'h88, 16'h0800, 10'd1, 4'hC, 4'h0, 64'h24), 1'b0,
                 64'h0, 24'h000888, 8'h08);
        tick(TO);
        ack_pulse(1'b1, 1'b0, 1'b0, 1'b0, 64'h11223344_55667788);
        chk("ack_vs_timeout_sc", 64'(bus.cpl_status), 64'(CPL_SC));
        chk("ack_vs_timeout_valid", 64'(bus.cpl_valid), 64'd1);
        tick(1);

        // reset during WAIT, later ack is stray and no completion follows
        exp_req_q.push_back('{MRD, 48'h40, 8'h0F, 64'h0, 24'h000999, 8'h09});
        send_cmd(mk(IOSF_MRD32, 8'h99, 16'h0900, 10'd1, 4'hF, 4'h0, 64'h40), 1'b0,
                 64'h0, 24'h000999, 8'h09);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("wait_rst_ready", 64'(bus.cmd_ready), 64'd1);
        chk("wait_rst_cpl", 64'(bus.cpl_valid), 64'd0);
        ack_pulse(1'b1, 1'b0, 1'b0, 1'b0, 64'h77);
        chk("post_rst_stray", 64'(bus.stray_ack), 64'd1);
        tick(TO + 2);
        chk("post_rst_no_cpl", 64'(bus.cpl_valid), 64'd0);

        // completion held while cpl_ready is low
        bus.cpl_ready = 1'b0;
        exp_req_q.push_back('{CFGRD, 48'h8, 8'h30, 64'h0, 24'h000AAA, 8'h0A});
        exp_cpl_q.push_back('{CPL_SC, 64'h0BADC0DE, 8'hAA, 16'h0A00});
        send_cmd(mk(IOSF_CFGRD0, 8'hAA, 16'h0A00, 10'd1, 4'h3, 4'h0, 64'hC), 1'b0,
                 64'h0, 24'h000AAA, 8'h0A);
        tick(1);
        ack_pulse(1'b1, 1'b0, 1'b0, 1'b0, 64'h0BADC0DE);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 64'(bus.cpl_valid), 64'd1);
            chk("hold_status", 64'(bus.cpl_status), 64'(CPL_SC));
            chk("hold_data", bus.cpl_data, 64'h0BADC0DE);
            chk("hold_tag", 64'(bus.cpl_tag), 64'hAA);
            chk("hold_rqid", 64'(bus.cpl_rqid), 64'h0A00);
            tick(1);
        end
        bus.cpl_ready = 1'b1;
        tick(1);
        chk("hold_released", 64'(bus.cpl_valid), 64'd0);

        tick(3);
        chk("req_queue_drained", 64'(exp_req_q.size()), 64'd0);
        chk("cpl_queue_drained", 64'(exp_cpl_q.size()), 64'd0);
        chk("par_err_count", 64'(n_par), 64'd1);
        chk("posted_err_count", 64'(n_posted), 64'd1);
        chk("stray_ack_count", 64'(n_stray), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_iosf_req_initiator.md
Name: cfg_iosf_req_initiator

Overview:
Initiator end of the config request/ack bus defined in rtlgen_pkg_207p2. Accepts one IOSF-style command (cfg_iosf_cmd_t plus write data) and checks its parity. Translates it to a single cfg_req_64bit_t transaction, waits for the cfg_ack_64bit_t from the rtlgen register target, and returns a completion. Sits between the IOSF primary/sideband front-end and the generated register file.

Parameters:
TIMEOUT_CYCLES, 1024, WAIT-state cycles before abort; legal range 2..65535.
TMR_W, 16, width of the timeout counter; must satisfy 2**TMR_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd  in  128  cfg_iosf_cmd_t
cmd_par  in  1  even parity over cmd, matching CmdParity()
cmd_wdata  in  64  lane-aligned write data
cmd_sai  in  24  security attribute
cmd_fid  in  8  function id
cfg_req  out  157  cfg_req_64bit_t
cfg_ack  in  68  cfg_ack_64bit_t
cpl_valid  out  1  completion available
cpl_ready  in  1  completion consumed
cpl_status  out  2  cfg_cpl_status_t: SC=0, UR=1, CA=2
cpl_data  out  64  read data; 0 for writes and errors
cpl_tag  out  8  cmd.tag echo
cpl_rqid  out  16  cmd.rqid echo
par_err  out  1  one-cycle pulse on a parity mismatch
posted_err  out  1  one-cycle pulse when a posted MWR misses or times out
stray_ack  out  1  one-cycle pulse when any ack bit is seen outside WAIT

Behaviour:
- Interface: single clock clk; rst is synchronous, active-high.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On accept, capture all cmd fields.
  - Parity fail (cmd_par != CmdParity(cmd)): pulse par_err, go to CPL with status CA.
  - Otherwise decode. Failure goes to CPL with status UR; success goes to ISSUE.
  - ISSUE: drive cfg_req.valid=1 for exactly one cycle, then go to WAIT.
  - WAIT: the timer increments each cycle. On an expected ack go to CPL, or to IDLE for MWR. At TIMEOUT_CYCLES go to CPL with CA, or to IDLE plus posted_err for MWR.
  - CPL: cpl_valid held until cpl_ready, then go to IDLE.
- Opcode map:
  - MRD32/MRD64 -> MRD; MWR32/MWR64 -> MWR.
  - IORD -> IORD; IOWR -> IOWR.
  - CFGRD0 -> CFGRD; CFGWR0 -> CFGWR.
  - All other opcodes -> UR, with no request issued.
- Decode checks:
  - length must be 1 or 2, else UR.
  - address[63:48] must be 0, else UR.
  - length 2 requires address[2]=0, else UR.
- Address: mem.offset = {address[47:3],3'b0}; io.offset = {address[15:3],3'b0}; cfg.offset = {address[11:3],3'b0}; pad fields are 0.
- be:
  - length 2: {lbe,fbe}.
  - length 1, address[2]=0: {4'h0,fbe}.
  - length 1, address[2]=1: {fbe,4'h0}.
- Request fields: data = cmd_wdata for writes, 0 for reads; sai and fid from the captured command.
- cfg_req is all-zero whenever valid=0.
- Expected ack: read ops use read_valid; write ops use write_valid. The opposite-class ack in WAIT is ignored.
- Ack status: miss=1 gives UR; otherwise SC. For reads, cpl_data = ack.data.
- Ack timing: acks are sampled only in WAIT. An ack coincident with ISSUE is a stray_ack and is lost, so the minimum ack latency is 1 cycle after the req.
- Ack and timeout in the same cycle: ack wins.
- MWR is posted: no completion is generated, but the block stays serialized until ack or timeout.
- Latency: accept at T, req.valid at T+1, ack at T+1+k (k>=1), cpl_valid at T+2+k.
- Reset: at any state go to IDLE. All outputs 0 except cmd_ready=1 in the cycle after reset deasserts. Timer is cleared and any pending completion is dropped.

Decomposition:
- Add cfg_cpl_status_t enum and the CPL_SC/UR/CA constants to the shared package.
- Add a function IosfToCfgOpcode() returning {supported, cfg_opcode_t} to the shared package.
- Natural sub-module: cfg_iosf_req_decode, combinational. It performs the parity check, opcode map, and address/be formation, and produces a cfg_req_64bit_t plus a status.
- The FSM and timer stay in the top.

Test Plan:
- MRD64 at address 0x1000, length 2, read ack at +3 with data 0xDEADBEEF_01234567 -> req opcode MRD, offset 0x1000, be 0xFF; cpl SC with that data at T+5.
- CFGWR0 at address 0x44, length 1, fbe 0xF, ack write_valid with write_miss=1 -> offset 0x40, be 0xF0, cpl UR, cpl_data 0.
- MWR32 with no ack -> timeout after TIMEOUT_CYCLES: posted_err pulses once, no cpl_valid, cmd_ready=1 on the next cycle.
- cmd_par flipped on an otherwise valid IORD -> par_err pulse, cfg_req.valid never asserted, cpl CA.
- Unsupported IOSF_SWAP64, and MRD with address[63:48]=1 -> each returns cpl UR with no request.
- Boundary cases:
  - ack in the ISSUE cycle -> stray_ack, the transaction then times out.
  - ack and timeout in the same cycle -> SC.
  - rst during WAIT -> IDLE, a later ack gives stray_ack.
  - cpl_ready held low for 5 cycles -> cpl fields stable.
